// File: rtl/elevator_call_scheduler_pkg.sv
// Shared types and constants for the elevator call scheduler.
// Floor 0 is the ground floor; floors 1..8 map onto req_onehot bits 0..7.
package elevator_pkg;

    localparam int NUM_FLOORS       = 9;
    localparam int FLOOR_W          = 4;
    localparam int DWELL_CYCLES_DEF = 10;

    // Encoding chosen so busy and door_open are single state bits.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_TRAVEL = 2'b01,
        ST_DWELL  = 2'b11
    } state_e;

    function automatic logic [7:0] floor_onehot(logic [FLOOR_W-1:0] fl);
        if (fl == 4'd0 || fl > 4'd8) return 8'd0;
        return 8'd1 << (fl - 4'd1);
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floor_mask(logic [FLOOR_W-1:0] fl);
        if (fl > 4'd8) return '0;
        return 9'd1 << fl;
    endfunction

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Call buttons and car status in, floor request and door status out.
// The scheduler uses the slave side; the car/environment the master side.
interface elevator_call_scheduler_if;
    import elevator_pkg::*;

    logic [7:0]            call_btn;
    logic                  call_ground;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  car_idle;
    logic [7:0]            req_onehot;
    logic [FLOOR_W-1:0]    target_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  door_open;
    logic                  busy;

    modport master (
        output call_btn, call_ground, current_floor, car_idle,
        input  req_onehot, target_floor, pending, door_open, busy
    );

    modport slave (
        input  call_btn, call_ground, current_floor, car_idle,
        output req_onehot, target_floor, pending, door_open, busy
    );

endinterface

// File: rtl/elevator_call_scheduler_call_edge_sync.sv
// Per-bit two-flop synchronizer followed by a registered rising-edge detector.
// rise_o is a one-cycle pulse, so a held button produces a single event.
module call_edge_sync #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN-style hall-call scheduler: latches calls, picks the next floor,
// holds the request while the car travels and opens the door for a dwell.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = DWELL_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    elevator_call_scheduler_if.slave bus
);

    state_e state_q, state_d;

    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic [7:0]            onehot_q, onehot_d;
    logic                  dir_up_q, dir_up_d;
    logic [15:0]           cnt_q, cnt_d;

    logic [NUM_FLOORS-1:0] rise;
    logic [NUM_FLOORS-1:0] clr;
    logic [NUM_FLOORS-1:0] blk;
    logic [FLOOR_W-1:0]    cur;
    logic [15:0]           pend_ext;

    logic               up_found, dn_found;
    logic [FLOOR_W-1:0] up_fl, dn_fl;
    logic               sel_ok, sel_up;
    logic [FLOOR_W-1:0] sel_fl;
    logic               here, arrived, dwell_done;

    call_edge_sync #(.W(NUM_FLOORS)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    ({bus.call_btn, bus.call_ground}),
        .rise_o (rise)
    );

    assign cur        = bus.current_floor;
    assign pend_ext   = {7'd0, pending_q};
    assign here       = bus.car_idle && (cur < 4'd9) && pend_ext[cur];
    assign arrived    = bus.car_idle && (cur == target_q);
    assign dwell_done = (cnt_q == 16'(DWELL_CYCLES - 1));

    // Nearest pending floor above and below the car.
    always_comb begin
        up_found = 1'b0;
        up_fl    = '0;
        dn_found = 1'b0;
        dn_fl    = '0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (pending_q[f] && (f > int'(cur))) begin
                up_found = 1'b1;
                up_fl    = FLOOR_W'(f);
            end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending_q[f] && (f < int'(cur))) begin
                dn_found = 1'b1;
                dn_fl    = FLOOR_W'(f);
            end
        end
    end

    always_comb begin
        sel_ok = 1'b0;
        sel_fl = '0;
        sel_up = dir_up_q;
        if (dir_up_q) begin
            if (up_found) begin
                sel_ok = 1'b1;
                sel_fl = up_fl;
            end else if (dn_found) begin
                sel_ok = 1'b1;
                sel_fl = dn_fl;
                sel_up = 1'b0;
            end
        end else begin
            if (dn_found) begin
                sel_ok = 1'b1;
                sel_fl = dn_fl;
            end else if (up_found) begin
                sel_ok = 1'b1;
                sel_fl = up_fl;
                sel_up = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            target_q  <= '0;
            onehot_q  <= '0;
            dir_up_q  <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            onehot_q  <= onehot_d;
            dir_up_q  <= dir_up_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (here)        state_d = ST_DWELL;
                else if (sel_ok) state_d = ST_TRAVEL;
            end
            ST_TRAVEL: if (arrived)    state_d = ST_DWELL;
            ST_DWELL:  if (dwell_done) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        target_d = target_q;
        onehot_d = onehot_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        clr      = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (here) begin
                    target_d = cur;
                    onehot_d = floor_onehot(cur);
                    clr      = floor_mask(cur);
                    cnt_d    = '0;
                end else if (sel_ok) begin
                    target_d = sel_fl;
                    onehot_d = floor_onehot(sel_fl);
                    dir_up_d = sel_up;
                end
            end
            ST_TRAVEL: begin
                if (arrived) begin
                    clr   = floor_mask(target_q);
                    cnt_d = '0;
                end
            end
            ST_DWELL: cnt_d = cnt_q + 16'd1;
            default: ;
        endcase
    end

    // The floor being served ignores presses while its door is open.
    assign blk       = (state_q == ST_DWELL) ? floor_mask(target_q) : '0;
    assign pending_d = (pending_q & ~clr) | (rise & ~blk);

    assign bus.pending      = pending_q;
    assign bus.target_floor = target_q;
    assign bus.req_onehot   = onehot_q;
    assign bus.busy         = state_q[0];
    assign bus.door_open    = state_q[1];

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench: reference scheduler model, directed table,
// hand-written scenarios with a simulated car, then random calls.
module tb_elevator_call_scheduler;
    import elevator_pkg::*;

    localparam int DW   = 4;
    localparam int MOVE = 11;
    localparam int M_IDLE = 0, M_TRAVEL = 1, M_DWELL = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    elevator_call_scheduler_if ifc ();

    elevator_call_scheduler #(.DWELL_CYCLES(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    logic [8:0] btn9;
    int         car_fl;
    bit         car_idle_b;
    bit         auto_car;
    int         mv_cnt;

    assign ifc.call_btn      = btn9[8:1];
    assign ifc.call_ground   = btn9[0];
    assign ifc.current_floor = 4'(car_fl);
    assign ifc.car_idle      = car_idle_b;

    int n_cmp = 0;
    int n_bad = 0;

    bit [2:0] m_h [9];
    bit [8:0] m_pend;
    int       m_mode, m_tgt, m_left;
    bit       m_up;

    function void model_reset();
        for (int f = 0; f < 9; f++) m_h[f] = '0;
        m_pend = '0;
        m_mode = M_IDLE;
        m_tgt  = 0;
        m_left = 0;
        m_up   = 1'b1;
    endfunction

    function int scan_pick(int cur);
        int lo, hi;
        lo = -1;
        hi = -1;
        for (int f = 0; f < 9; f++) begin
            if (m_pend[f] && f > cur && lo < 0) lo = f;
            if (m_pend[f] && f < cur) hi = f;
        end
        if (m_up) begin
            if (lo >= 0) return lo;
            if (hi >= 0) begin m_up = 1'b0; return hi; end
        end else begin
            if (hi >= 0) return hi;
            if (lo >= 0) begin m_up = 1'b1; return lo; end
        end
        return -1;
    endfunction

    function void model_step();
        bit [8:0] rise;
        int old_mode, old_tgt, cur, pk;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int f = 0; f < 9; f++) begin
            rise[f] = m_h[f][1] & ~m_h[f][2];
            m_h[f]  = {m_h[f][1:0], btn9[f]};
        end
        old_mode = m_mode;
        old_tgt  = m_tgt;
        cur      = car_fl;
        case (m_mode)
            M_IDLE: begin
                if (car_idle_b && cur <= 8 && m_pend[cur]) begin
                    m_mode = M_DWELL;
                    m_tgt  = cur;
                    m_pend[cur] = 1'b0;
                    m_left = DW;
                end else begin
                    pk = scan_pick(cur);
                    if (pk >= 0) begin
                        m_tgt  = pk;
                        m_mode = M_TRAVEL;
                    end
                end
            end
            M_TRAVEL: begin
                if (car_idle_b && cur == m_tgt) begin
                    m_mode = M_DWELL;
                    m_pend[m_tgt] = 1'b0;
                    m_left = DW;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_mode = M_IDLE;
            end
        endcase
        for (int f = 0; f < 9; f++)
            if (rise[f] && !(old_mode == M_DWELL && f == old_tgt))
                m_pend[f] = 1'b1;
    endfunction

    function logic [22:0] model_vec();
        logic [7:0] oh;
        oh = (m_tgt == 0) ? 8'h00 : 8'(1 << (m_tgt - 1));
        return {m_pend, 4'(m_tgt), oh, m_mode == M_DWELL, m_mode != M_IDLE};
    endfunction

    function logic [22:0] dut_vec();
        return {ifc.pending, ifc.target_floor, ifc.req_onehot,
                ifc.door_open, ifc.busy};
    endfunction

    task automatic check(string nm, logic [22:0] act, logic [22:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got pend=%h tgt=%0d oh=%h door=%b busy=%b, want pend=%h tgt=%0d oh=%h door=%b busy=%b",
                     nm, act[22:14], act[13:10], act[9:2], act[1], act[0],
                     exp[22:14], exp[13:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic car_step();
        int tgt;
        tgt = int'(ifc.target_floor);
        if (ifc.busy && car_fl != tgt) begin
            car_idle_b = 1'b0;
            mv_cnt++;
            if (mv_cnt >= MOVE) begin
                car_fl += (tgt > car_fl) ? 1 : -1;
                mv_cnt = 0;
                car_idle_b = (car_fl == tgt);
            end
        end else begin
            car_idle_b = 1'b1;
            mv_cnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model", dut_vec(), model_vec());
        if (auto_car) car_step();
    endtask

    task automatic press(logic [8:0] b, int n);
        btn9 = b;
        repeat (n) tick();
        btn9 = '0;
    endtask

    task automatic wait_door(string nm, int fl, logic [7:0] oh);
        int k;
        k = 0;
        while (!ifc.door_open && k < 3000) begin tick(); k++; end
        n_cmp++;
        if (k >= 3000) begin
            n_bad++;
            $display("FAIL %s_timeout: door_open=0 after %0d cycles, want 1", nm, k);
        end
        check(nm, dut_vec(),
              {ifc.pending, 4'(fl), oh, 1'b1, 1'b1} & 23'h003FFF |
              {ifc.pending, 14'd0});
        k = 0;
        while (ifc.door_open && k < 100) begin tick(); k++; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("reset_async", dut_vec(), 23'd0);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [8:0] btn;
        int         fl;
        bit         idle;
        int         n;
        logic [8:0] pend;
        logic [3:0] tgt;
        logic [7:0] oh;
        bit         door;
        bit         busy;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{9'h000, 0, 1, 1, 9'h000, 4'd0, 8'h00, 0, 0};
        tbl[1]  = '{9'h008, 0, 1, 2, 9'h000, 4'd0, 8'h00, 0, 0};
        tbl[2]  = '{9'h008, 0, 1, 1, 9'h008, 4'd0, 8'h00, 0, 0};
        tbl[3]  = '{9'h000, 0, 1, 1, 9'h008, 4'd3, 8'h04, 0, 1};
        tbl[4]  = '{9'h000, 3, 0, 3, 9'h008, 4'd3, 8'h04, 0, 1};
        tbl[5]  = '{9'h000, 3, 1, 1, 9'h000, 4'd3, 8'h04, 1, 1};
        tbl[6]  = '{9'h000, 3, 1, 3, 9'h000, 4'd3, 8'h04, 1, 1};
        tbl[7]  = '{9'h000, 3, 1, 1, 9'h000, 4'd3, 8'h04, 0, 0};
        tbl[8]  = '{9'h008, 3, 1, 3, 9'h008, 4'd3, 8'h04, 0, 0};
        tbl[9]  = '{9'h000, 3, 1, 1, 9'h000, 4'd3, 8'h04, 1, 1};
        tbl[10] = '{9'h008, 3, 1, 3, 9'h000, 4'd3, 8'h04, 1, 1};
        tbl[11] = '{9'h008, 3, 1, 1, 9'h000, 4'd3, 8'h04, 0, 0};
        tbl[12] = '{9'h000, 3, 1, 2, 9'h000, 4'd3, 8'h04, 0, 0};

        btn9 = '0;
        car_fl = 0;
        car_idle_b = 1'b1;
        auto_car = 1'b0;
        mv_cnt = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check("reset_state", dut_vec(), 23'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            btn9 = tbl[i].btn;
            car_fl = tbl[i].fl;
            car_idle_b = tbl[i].idle;
            repeat (tbl[i].n) tick();
            check($sformatf("vec%0d", i), dut_vec(),
                  {tbl[i].pend, tbl[i].tgt, tbl[i].oh, tbl[i].door, tbl[i].busy});
        end

        // Simulated car from here on.
        btn9 = '0;
        car_fl = 0;
        car_idle_b = 1'b1;
        auto_car = 1'b1;
        do_reset();

        press(9'h024, 4);
        wait_door("serve2", 2, 8'h02);
        wait_door("serve5", 5, 8'h10);

        press(9'h088, 4);
        wait_door("serve7", 7, 8'h40);
        wait_door("serve3", 3, 8'h04);

        press(9'h040, 4);
        wait_door("serve6", 6, 8'h20);
        press(9'h001, 4);
        wait_door("serve0", 0, 8'h00);

        press(9'h100, 4);
        repeat (40) tick();
        check("travel8", {ifc.target_floor, ifc.busy, ifc.door_open},
              {4'd8, 1'b1, 1'b0});
        do_reset();
        repeat (5) tick();
        check("idle_after_rst", dut_vec(), 23'd0);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0)
                btn9 = 9'($urandom & $urandom & $urandom);
            tick();
        end
        btn9 = '0;
        repeat (400) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/elevator_call_scheduler.md
ELEVATOR_CALL_SCHEDULER -- requirements
Module: elevator_call_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 10: number of clk cycles door_open stays high at a served floor (legal 1..2^16-1).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 call_btn  input  8  hall-call buttons, asynchronous level inputs; bit i = call for floor i+1.
REQ-005 call_ground  input  1  hall-call button for floor 0, asynchronous level input.
REQ-006 current_floor  input  4  floor reported by the elevator car, 0..8; values 9..15 never match any target.
REQ-007 car_idle  input  1  high when the car is stopped and not moving.
REQ-008 req_onehot  output  8  floor request to the car; floor f>=1 -> only bit f-1 set; floor 0 -> all zero.
REQ-009 target_floor  output  4  binary floor currently requested, 0..8.
REQ-010 pending  output  9  latched outstanding calls; bit f = floor f.
REQ-011 door_open  output  1  high during dwell at a served floor.
REQ-012 busy  output  1  high in TRAVEL or DWELL.

Function
REQ-013 Each of the 9 call inputs SHALL pass through a 2-flop synchronizer and a registered rising-edge detector; a call held high sets its pending bit on the 3rd rising clk edge sampling it high; holding the button sets the bit once only.
REQ-014 A pending bit SHALL stay set until its floor is served; repeated presses while set have no effect.
REQ-015 State machine states: IDLE, TRAVEL, DWELL; reset state IDLE.
REQ-016 Direction register dir_up (reset 1) SHALL implement SCAN selection from pending and current_floor.
REQ-017 Selection, dir_up=1: lowest pending floor > current_floor; if none, highest pending floor < current_floor with dir_up cleared.
REQ-018 Selection, dir_up=0: highest pending floor < current_floor; if none, lowest pending floor > current_floor with dir_up set.
REQ-019 IDLE: if pending[current_floor] and car_idle -> DWELL with target_floor=current_floor; else if selection exists -> load target_floor/req_onehot, go TRAVEL; else stay.
REQ-020 TRAVEL: target_floor and req_onehot SHALL remain constant; new calls only update pending (no retargeting).
REQ-021 TRAVEL -> DWELL on the first edge where car_idle=1 and current_floor==target_floor.
REQ-022 On entering DWELL the pending bit of target_floor SHALL clear in the same edge; a press of that floor during DWELL is ignored.
REQ-023 DWELL: door_open=1 for exactly DWELL_CYCLES cycles, then IDLE; selection happens in the following IDLE cycle.
REQ-024 req_onehot/target_floor SHALL hold their last value in IDLE so the car stays put.
REQ-025 A call for a floor arriving the same edge that floor's bit clears (outside DWELL) SHALL set the bit (set wins).
REQ-026 busy = (state != IDLE); door_open = (state == DWELL); both registered-state decodes, glitch-free.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, pending 0, target_floor 0, req_onehot 0, door_open 0, busy 0, dir_up 1, dwell counter 0, synchronizer/edge flops 0.
REQ-028 Reset mid-TRAVEL or mid-DWELL discards all calls; operation resumes from IDLE one edge after rst_n rises.

Structure
REQ-029 Package elevator_pkg SHALL hold the state enumeration, NUM_FLOORS=9, FLOOR_W=4, and the default DWELL_CYCLES.
REQ-030 One sub-module, call_edge_sync (per-bit 2-flop synchronizer + rising-edge pulse), SHALL be instantiated 9 wide.

Verification (DWELL_CYCLES=4, behavioural car moving 1 floor per 11 cycles)
REQ-031 Reset, press call_btn[2] (floor 3) -> pending=9'h008 after 3 edges, req_onehot=8'b00000100, busy=1; car reaches 3 -> door_open 4 cycles, pending=0, busy=0.
REQ-032 Car at 0 idle, press floors 5 and 2 in same cycle -> serves 2 then 5 (req_onehot 8'h02 then 8'h10).
REQ-033 Car at 5 going up, pending {7,3} -> serves 7, dir flips, then 3; req_onehot 8'h40 then 8'h04.
REQ-034 Car idle at 4, press floor 4 -> DWELL directly, no TRAVEL, req_onehot unchanged 8'h08; press floor 4 during dwell -> pending stays 0.
REQ-035 Press call_ground while car at 6 -> req_onehot=8'h00, target_floor=0, car returns to 0, door_open.
REQ-036 Assert rst_n low mid-TRAVEL toward 8 -> all outputs zero immediately, pending cleared, stays IDLE after release.
